// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port among N clients.
// Requests are registered into a one-entry output stage and tagged with the
// client ID in the upper opaque bits; responses are routed back by that tag.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cli_req_{val,rdy,opaque,payload}   per-client request channels (sliced)
//   cli_resp_{val,rdy}            per-client response handshake
//   cli_resp_{opaque,payload}     broadcast response data, ID stripped
//   mem_req_*, mem_resp_*         downstream memory port
//   tag_err                       sticky flag for a response with ID >= N
module mem_port_arbiter #(
    parameter int p_num_clients       = 2,
    parameter int p_opaq_bits         = 8,
    parameter int p_payload_bits      = 67,
    parameter int p_resp_payload_bits = 35,
    parameter int p_max_outstanding   = 4,
    parameter int p_id_bits           = $clog2(p_num_clients)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [p_num_clients-1:0]               cli_req_val,
    output logic [p_num_clients-1:0]               cli_req_rdy,
    input  logic [p_num_clients*p_opaq_bits-1:0]    cli_req_opaque,
    input  logic [p_num_clients*p_payload_bits-1:0] cli_req_payload,
    output logic [p_num_clients-1:0]               cli_resp_val,
    input  logic [p_num_clients-1:0]               cli_resp_rdy,
    output logic [p_opaq_bits-1:0]                 cli_resp_opaque,
    output logic [p_resp_payload_bits-1:0]         cli_resp_payload,
    output logic                                   mem_req_val,
    input  logic                                   mem_req_rdy,
    output logic [p_id_bits+p_opaq_bits-1:0]       mem_req_opaque,
    output logic [p_payload_bits-1:0]              mem_req_payload,
    input  logic                                   mem_resp_val,
    output logic                                   mem_resp_rdy,
    input  logic [p_id_bits+p_opaq_bits-1:0]       mem_resp_opaque,
    input  logic [p_resp_payload_bits-1:0]         mem_resp_payload,
    output logic                                   tag_err
);

    localparam int N  = p_num_clients;
    localparam int IB = p_id_bits;
    localparam int OB = p_opaq_bits;
    localparam int PB = p_payload_bits;
    localparam int CW = $clog2(p_max_outstanding + 1);

    logic          stg_val_q, stg_val_d;
    logic [IB-1:0] stg_id_q;
    logic [OB-1:0] stg_opq_q;
    logic [PB-1:0] stg_pay_q;
    logic [IB-1:0] prio_q, prio_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic          tag_err_q, tag_err_d;

    logic [N-1:0]  elig;
    logic [N-1:0]  inc, dec;
    logic          found, can_accept, accept;
    logic [IB-1:0] gnt_id;
    logic [IB-1:0] resp_id;
    logic          resp_legal, resp_sel_rdy;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = cli_req_val[i] &&
                      (cnt_q[i] < CW'(p_max_outstanding));
        end
    end

    // Scan from prio upward, wrapping, for the first eligible client.
    always_comb begin : p_scan
        int j;
        found  = 1'b0;
        gnt_id = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(prio_q) + k;
            if (j >= N) j = j - N;
            if (!found && elig[j]) begin
                found  = 1'b1;
                gnt_id = IB'(j);
            end
        end
    end

    // Stage refills in the same cycle it drains.
    assign can_accept  = !stg_val_q || mem_req_rdy;
    assign accept      = can_accept && found;
    assign cli_req_rdy = accept ? ({{(N-1){1'b0}}, 1'b1} << gnt_id) : '0;

    always_comb begin
        stg_val_d = stg_val_q;
        if (accept)           stg_val_d = 1'b1;
        else if (mem_req_rdy) stg_val_d = 1'b0;
        prio_d = prio_q;
        if (accept) begin
            prio_d = (gnt_id == IB'(N - 1)) ? '0 : gnt_id + IB'(1);
        end
    end

    // A response to an idle client (e.g. straggler after reset) must not
    // wrap the counter below zero.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inc[i]   = accept && (gnt_id == IB'(i));
            dec[i]   = cli_resp_val[i] && cli_resp_rdy[i] &&
                       (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i])      cnt_d[i] = cnt_q[i] + CW'(1);
            else if (dec[i] && !inc[i]) cnt_d[i] = cnt_q[i] - CW'(1);
        end
    end

    assign resp_id = mem_resp_opaque[OB +: IB];

    // Loop compare keeps the legality test free of out-of-range constants.
    always_comb begin
        resp_legal   = 1'b0;
        resp_sel_rdy = 1'b0;
        cli_resp_val = '0;
        for (int i = 0; i < N; i++) begin
            if (resp_id == IB'(i)) begin
                resp_legal      = 1'b1;
                resp_sel_rdy    = cli_resp_rdy[i];
                cli_resp_val[i] = mem_resp_val;
            end
        end
        mem_resp_rdy = resp_legal ? resp_sel_rdy : 1'b1;
        tag_err_d    = tag_err_q || (mem_resp_val && !resp_legal);
    end

    assign cli_resp_opaque  = mem_resp_opaque[OB-1:0];
    assign cli_resp_payload = mem_resp_payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_val_q <= 1'b0;
            prio_q    <= '0;
            tag_err_q <= 1'b0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            stg_val_q <= stg_val_d;
            prio_q    <= prio_d;
            tag_err_q <= tag_err_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            stg_id_q  <= gnt_id;
            stg_opq_q <= cli_req_opaque[gnt_id*OB +: OB];
            stg_pay_q <= cli_req_payload[gnt_id*PB +: PB];
        end
    end

    assign mem_req_val     = stg_val_q;
    assign mem_req_opaque  = {stg_id_q, stg_opq_q};
    assign mem_req_payload = stg_pay_q;
    assign tag_err         = tag_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Instance a uses 2 clients, instance b uses 3 clients (illegal-tag cases).
module tb_mem_port_arbiter;

    logic clk;
    int   chk;
    int   err;

    logic            a_rst;
    logic [1:0]      a_val, a_rdy;
    logic [1:0][7:0] a_opq;
    logic [1:0][66:0] a_pay;
    logic [1:0]      a_resp_val, a_resp_rdy;
    logic [7:0]      a_resp_opq;
    logic [34:0]     a_resp_pay;
    logic            a_mreq_val, a_mreq_rdy;
    logic [8:0]      a_mreq_opq;
    logic [66:0]     a_mreq_pay;
    logic            a_mresp_val, a_mresp_rdy;
    logic [8:0]      a_mresp_opq;
    logic [34:0]     a_mresp_pay;
    logic            a_tag_err;

    logic            b_rst;
    logic [2:0]      b_val, b_rdy;
    logic [2:0][7:0] b_opq;
    logic [2:0][66:0] b_pay;
    logic [2:0]      b_resp_val, b_resp_rdy;
    logic [7:0]      b_resp_opq;
    logic [34:0]     b_resp_pay;
    logic            b_mreq_val, b_mreq_rdy;
    logic [9:0]      b_mreq_opq;
    logic [66:0]     b_mreq_pay;
    logic            b_mresp_val, b_mresp_rdy;
    logic [9:0]      b_mresp_opq;
    logic [34:0]     b_mresp_pay;
    logic            b_tag_err;

    mem_port_arbiter u_a (
        .clk              (clk),
        .rst              (a_rst),
        .cli_req_val      (a_val),
        .cli_req_rdy      (a_rdy),
        .cli_req_opaque   (a_opq),
        .cli_req_payload  (a_pay),
        .cli_resp_val     (a_resp_val),
        .cli_resp_rdy     (a_resp_rdy),
        .cli_resp_opaque  (a_resp_opq),
        .cli_resp_payload (a_resp_pay),
        .mem_req_val      (a_mreq_val),
        .mem_req_rdy      (a_mreq_rdy),
        .mem_req_opaque   (a_mreq_opq),
        .mem_req_payload  (a_mreq_pay),
        .mem_resp_val     (a_mresp_val),
        .mem_resp_rdy     (a_mresp_rdy),
        .mem_resp_opaque  (a_mresp_opq),
        .mem_resp_payload (a_mresp_pay),
        .tag_err          (a_tag_err)
    );

    mem_port_arbiter #(.p_num_clients(3)) u_b (
        .clk              (clk),
        .rst              (b_rst),
        .cli_req_val      (b_val),
        .cli_req_rdy      (b_rdy),
        .cli_req_opaque   (b_opq),
        .cli_req_payload  (b_pay),
        .cli_resp_val     (b_resp_val),
        .cli_resp_rdy     (b_resp_rdy),
        .cli_resp_opaque  (b_resp_opq),
        .cli_resp_payload (b_resp_pay),
        .mem_req_val      (b_mreq_val),
        .mem_req_rdy      (b_mreq_rdy),
        .mem_req_opaque   (b_mreq_opq),
        .mem_req_payload  (b_mreq_pay),
        .mem_resp_val     (b_mresp_val),
        .mem_resp_rdy     (b_mresp_rdy),
        .mem_resp_opaque  (b_mresp_opq),
        .mem_resp_payload (b_mresp_pay),
        .tag_err          (b_tag_err)
    );

    always #5 clk = ~clk;

    task automatic rst_a();
        @(negedge clk);
        a_rst       = 1'b1;
        a_val       = '0;
        a_mreq_rdy  = 1'b1;
        a_mresp_val = 1'b0;
        a_resp_rdy  = 2'b11;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0;
    endtask

    task automatic rst_b();
        @(negedge clk);
        b_rst       = 1'b1;
        b_val       = '0;
        b_mreq_rdy  = 1'b1;
        b_mresp_val = 1'b0;
        b_resp_rdy  = 3'b111;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0;
    endtask

    task automatic test_reset();
        rst_a();
        #1;
        chk++;
        if (a_mreq_val !== 1'b0) begin
            err++;
            $display("FAIL reset_mreq_val got %b want 0", a_mreq_val);
        end
        chk++;
        if (a_tag_err !== 1'b0) begin
            err++;
            $display("FAIL reset_tag_err got %b want 0", a_tag_err);
        end
        chk++;
        if (a_rdy !== 2'b00) begin
            err++;
            $display("FAIL reset_rdy_idle got %b want 00", a_rdy);
        end
        a_val = 2'b11;
        #1;
        chk++;
        if (a_rdy !== 2'b01) begin
            err++;
            $display("FAIL reset_prio got %b want 01", a_rdy);
        end
        a_val = 2'b00;
    endtask

    task automatic test_single();
        rst_a();
        a_val    = 2'b01;
        a_opq[0] = 8'h11;
        a_pay[0] = 67'h100;
        #1;
        chk++;
        if (a_rdy !== 2'b01) begin
            err++;
            $display("FAIL single_rdy got %b want 01", a_rdy);
        end
        @(posedge clk);
        #1;
        chk++;
        if (a_mreq_val !== 1'b1 || a_mreq_opq !== 9'h011) begin
            err++;
            $display("FAIL single_req got %b/%h want 1/011",
                     a_mreq_val, a_mreq_opq);
        end
        chk++;
        if (a_mreq_pay !== 67'h100) begin
            err++;
            $display("FAIL single_pay got %h want 100", a_mreq_pay);
        end
        @(negedge clk);
        a_val = 2'b00;
        @(posedge clk);
        #1;
        chk++;
        if (a_mreq_val !== 1'b0) begin
            err++;
            $display("FAIL single_drain got %b want 0", a_mreq_val);
        end
        @(negedge clk);
        a_mresp_val = 1'b1;
        a_mresp_opq = 9'h011;
        a_mresp_pay = 35'h5A5;
        #1;
        chk++;
        if (a_resp_val !== 2'b01 || a_resp_opq !== 8'h11) begin
            err++;
            $display("FAIL single_resp got %b/%h want 01/11",
                     a_resp_val, a_resp_opq);
        end
        chk++;
        if (a_resp_pay !== 35'h5A5 || a_mresp_rdy !== 1'b1) begin
            err++;
            $display("FAIL single_resp_pay got %h/%b want 5a5/1",
                     a_resp_pay, a_mresp_rdy);
        end
        @(posedge clk);
        @(negedge clk);
        a_mresp_val = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] er;
        logic [8:0] eo;
        rst_a();
        a_opq[0] = 8'hA0;
        a_opq[1] = 8'hB1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            a_val = 2'b11;
            er = (i % 2 == 0) ? 2'b01 : 2'b10;
            eo = (i % 2 == 0) ? 9'h0A0 : 9'h1B1;
            #1;
            chk++;
            if (a_rdy !== er) begin
                err++;
                $display("FAIL rr_rdy[%0d] got %b want %b", i, a_rdy, er);
            end
            @(posedge clk);
            #1;
            chk++;
            if (a_mreq_val !== 1'b1 || a_mreq_opq !== eo) begin
                err++;
                $display("FAIL rr_opq[%0d] got %b/%h want 1/%h",
                         i, a_mreq_val, a_mreq_opq, eo);
            end
        end
        @(negedge clk);
        a_val = 2'b00;
    endtask

    task automatic test_backpressure();
        rst_a();
        a_val      = 2'b01;
        a_opq[0]   = 8'h22;
        a_mreq_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_opq[0] = 8'h33;
        a_opq[1] = 8'h44;
        a_val    = 2'b11;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk++;
            if (a_rdy !== 2'b00) begin
                err++;
                $display("FAIL bp_rdy[%0d] got %b want 00", k, a_rdy);
            end
            chk++;
            if (a_mreq_val !== 1'b1 || a_mreq_opq !== 9'h022) begin
                err++;
                $display("FAIL bp_hold[%0d] got %b/%h want 1/022",
                         k, a_mreq_val, a_mreq_opq);
            end
            @(posedge clk);
        end
        @(negedge clk);
        a_mreq_rdy = 1'b1;
        #1;
        chk++;
        if (a_rdy !== 2'b10) begin
            err++;
            $display("FAIL bp_release_rdy got %b want 10", a_rdy);
        end
        @(posedge clk);
        #1;
        chk++;
        if (a_mreq_val !== 1'b1 || a_mreq_opq !== 9'h144) begin
            err++;
            $display("FAIL bp_refill got %b/%h want 1/144",
                     a_mreq_val, a_mreq_opq);
        end
        @(posedge clk);
        #1;
        chk++;
        if (a_mreq_val !== 1'b1 || a_mreq_opq !== 9'h033) begin
            err++;
            $display("FAIL bp_next got %b/%h want 1/033",
                     a_mreq_val, a_mreq_opq);
        end
        @(negedge clk);
        a_val = 2'b00;
    endtask

    task automatic test_outstanding_cap();
        rst_a();
        a_opq[1] = 8'hC1;
        a_opq[0] = 8'hC0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            a_val = 2'b10;
            #1;
            chk++;
            if (a_rdy !== 2'b10) begin
                err++;
                $display("FAIL cap_issue[%0d] got %b want 10", i, a_rdy);
            end
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk++;
        if (a_rdy !== 2'b00) begin
            err++;
            $display("FAIL cap_stall got %b want 00", a_rdy);
        end
        a_val = 2'b11;
        #1;
        chk++;
        if (a_rdy !== 2'b01) begin
            err++;
            $display("FAIL cap_other got %b want 01", a_rdy);
        end
        @(posedge clk);
        @(negedge clk);
        a_val       = 2'b10;
        a_mresp_val = 1'b1;
        a_mresp_opq = 9'h1C1;
        #1;
        chk++;
        if (a_resp_val !== 2'b10 || a_rdy !== 2'b00) begin
            err++;
            $display("FAIL cap_resp got %b/%b want 10/00",
                     a_resp_val, a_rdy);
        end
        @(posedge clk);
        @(negedge clk);
        a_mresp_val = 1'b0;
        #1;
        chk++;
        if (a_rdy !== 2'b10) begin
            err++;
            $display("FAIL cap_resume got %b want 10", a_rdy);
        end
        @(posedge clk);
        #1;
        chk++;
        if (a_mreq_val !== 1'b1 || a_mreq_opq !== 9'h1C1) begin
            err++;
            $display("FAIL cap_fifth got %b/%h want 1/1c1",
                     a_mreq_val, a_mreq_opq);
        end
        @(negedge clk);
        a_val = 2'b00;
    endtask

    task automatic test_simultaneous();
        rst_a();
        a_opq[0] = 8'hD0;
        a_val    = 2'b01;
        @(posedge clk);
        @(negedge clk);
        a_mresp_val = 1'b1;
        a_mresp_opq = 9'h0D0;
        #1;
        chk++;
        if (a_rdy !== 2'b01 || a_resp_val !== 2'b01) begin
            err++;
            $display("FAIL sim_both got %b/%b want 01/01",
                     a_rdy, a_resp_val);
        end
        @(posedge clk);
        @(negedge clk);
        a_val      = 2'b00;
        a_resp_rdy = 2'b00;
        #1;
        chk++;
        if (a_mresp_rdy !== 1'b0 || a_resp_val !== 2'b01) begin
            err++;
            $display("FAIL sim_resp_bp got %b/%b want 0/01",
                     a_mresp_rdy, a_resp_val);
        end
        @(posedge clk);
        @(negedge clk);
        a_mresp_val = 1'b0;
        a_resp_rdy  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            a_val = 2'b01;
            #1;
            chk++;
            if (a_rdy !== 2'b01) begin
                err++;
                $display("FAIL sim_fill[%0d] got %b want 01", i, a_rdy);
            end
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk++;
        if (a_rdy !== 2'b00) begin
            err++;
            $display("FAIL sim_cap got %b want 00", a_rdy);
        end
        a_val = 2'b00;
    endtask

    task automatic test_illegal_tag();
        rst_b();
        b_mresp_val = 1'b1;
        b_mresp_opq = 10'h355;
        b_resp_rdy  = 3'b000;
        #1;
        chk++;
        if (b_resp_val !== 3'b000 || b_mresp_rdy !== 1'b1) begin
            err++;
            $display("FAIL ill_route got %b/%b want 000/1",
                     b_resp_val, b_mresp_rdy);
        end
        chk++;
        if (b_tag_err !== 1'b0) begin
            err++;
            $display("FAIL ill_pre got %b want 0", b_tag_err);
        end
        @(posedge clk);
        #1;
        chk++;
        if (b_tag_err !== 1'b1) begin
            err++;
            $display("FAIL ill_set got %b want 1", b_tag_err);
        end
        @(negedge clk);
        b_mresp_opq = 10'h277;
        b_resp_rdy  = 3'b111;
        #1;
        chk++;
        if (b_resp_val !== 3'b100 || b_resp_opq !== 8'h77) begin
            err++;
            $display("FAIL ill_legal got %b/%h want 100/77",
                     b_resp_val, b_resp_opq);
        end
        @(posedge clk);
        #1;
        chk++;
        if (b_tag_err !== 1'b1) begin
            err++;
            $display("FAIL ill_sticky got %b want 1", b_tag_err);
        end
        @(negedge clk);
        b_mresp_val = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        b_val      = 3'b100;
        b_opq[2]   = 8'hE2;
        b_mreq_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk++;
        if (b_mreq_val !== 1'b1 || b_mreq_opq !== 10'h2E2) begin
            err++;
            $display("FAIL mid_full got %b/%h want 1/2e2",
                     b_mreq_val, b_mreq_opq);
        end
        @(negedge clk);
        b_val = 3'b000;
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        chk++;
        if (b_mreq_val !== 1'b0 || b_tag_err !== 1'b0) begin
            err++;
            $display("FAIL mid_rst got %b/%b want 0/0",
                     b_mreq_val, b_tag_err);
        end
        @(negedge clk);
        b_rst       = 1'b0;
        b_mreq_rdy  = 1'b1;
        b_mresp_val = 1'b1;
        b_mresp_opq = 10'h2E2;
        #1;
        chk++;
        if (b_resp_val !== 3'b100) begin
            err++;
            $display("FAIL mid_late_resp got %b want 100", b_resp_val);
        end
        @(posedge clk);
        @(negedge clk);
        b_mresp_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            b_val = 3'b100;
            #1;
            chk++;
            if (b_rdy !== 3'b100) begin
                err++;
                $display("FAIL mid_fill[%0d] got %b want 100", i, b_rdy);
            end
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk++;
        if (b_rdy !== 3'b000) begin
            err++;
            $display("FAIL mid_cap got %b want 000", b_rdy);
        end
        b_val = 3'b000;
    endtask

    initial begin
        clk         = 1'b0;
        chk         = 0;
        err         = 0;
        a_rst       = 1'b1;
        a_val       = '0;
        a_opq       = '0;
        a_pay       = '0;
        a_resp_rdy  = 2'b11;
        a_mreq_rdy  = 1'b1;
        a_mresp_val = 1'b0;
        a_mresp_opq = '0;
        a_mresp_pay = '0;
        b_rst       = 1'b1;
        b_val       = '0;
        b_opq       = '0;
        b_pay       = '0;
        b_resp_rdy  = 3'b111;
        b_mreq_rdy  = 1'b1;
        b_mresp_val = 1'b0;
        b_mresp_opq = '0;
        b_mresp_pay = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_outstanding_cap();
        test_simultaneous();
        test_illegal_tag();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
